// File: rtl/softmax_normalizer.sv
// softmax_normalizer: final divide stage of the tree softmax. Each lane is
// scaled by the reciprocal of the denominator that matches its segment length.
// The result is a Q1.15 probability per lane.
// Latency: 4 enabled cycles (S1 select, S2 LOD+LUT, S3 multiply, S4 shift/sat).
// Backpressure: none; i_en=0 freezes every stage, including the outputs.
// Ports: i_clk/i_rst (sync, active-high), i_en, i_valid, i_length_mode,
//   i_global_sum, i_sum64_0, i_sum32_0..1, i_sum16_0..3, i_in_flat (64x16b);
//   o_valid, o_prob_flat (64x16b), o_div_zero (per 16-lane slot), o_length_mode_byp.
// Optional: define NORM_ROUND_EN for round-to-nearest in S4 (default truncates).
module softmax_normalizer #(
  parameter int LANES    = 64,
  parameter int LUT_BITS = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_valid,
  input  logic [3:0]           i_length_mode,
  input  logic [31:0]          i_global_sum,
  input  logic [31:0]          i_sum64_0,
  input  logic [31:0]          i_sum32_0,
  input  logic [31:0]          i_sum32_1,
  input  logic [31:0]          i_sum16_0,
  input  logic [31:0]          i_sum16_1,
  input  logic [31:0]          i_sum16_2,
  input  logic [31:0]          i_sum16_3,
  input  logic [LANES*16-1:0]  i_in_flat,
  output logic                 o_valid,
  output logic [LANES*16-1:0]  o_prob_flat,
  output logic [3:0]           o_div_zero,
  output logic [3:0]           o_length_mode_byp
);

  localparam int SLOTS = 4;
  localparam int NSEG  = LANES / SLOTS;

  // r = min(65535, floor(2^(16+LUT_BITS) / (2^LUT_BITS + f))); f=0 clips to 65535.
  function automatic logic [15:0] lut_val(input int f);
    longint r;
    r = (64'sd1 <<< (16 + LUT_BITS)) / ((64'sd1 <<< LUT_BITS) + longint'(f));
    if (r > 65535) r = 65535;
    return r[15:0];
  endfunction

  function automatic logic [4:0] lod(input logic [31:0] s);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (s[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  logic [15:0] w_lut [1<<LUT_BITS];
  for (genvar g = 0; g < (1<<LUT_BITS); g++) begin : g_lut
    assign w_lut[g] = lut_val(g);
  end

  // Denominator select
  logic [31:0] w_den [SLOTS];
  always_comb begin
    for (int s = 0; s < SLOTS; s++) w_den[s] = i_global_sum;
    case (i_length_mode)
      4'd0: begin
        w_den[0] = i_sum16_0; w_den[1] = i_sum16_1;
        w_den[2] = i_sum16_2; w_den[3] = i_sum16_3;
      end
      4'd1: begin
        w_den[0] = i_sum32_0; w_den[1] = i_sum32_0;
        w_den[2] = i_sum32_1; w_den[3] = i_sum32_1;
      end
      4'd2: begin
        for (int s = 0; s < SLOTS; s++) w_den[s] = i_sum64_0;
      end
      default: ;
    endcase
  end

  // Pipeline registers
  logic              r_s1_vld, r_s2_vld, r_s3_vld, r_out_vld;
  logic [3:0]        r_s1_mode, r_s2_mode, r_s3_mode, r_out_mode;
  logic [15:0]       r_s1_lane [LANES];
  logic [31:0]       r_s1_den  [SLOTS];
  logic [15:0]       r_s2_lane [LANES];
  logic [4:0]        r_s2_e    [SLOTS];
  logic [15:0]       r_s2_r    [SLOTS];
  logic [SLOTS-1:0]  r_s2_zero, r_s3_zero, r_out_dz;
  logic [31:0]       r_s3_prod [LANES];
  logic [4:0]        r_s3_e    [SLOTS];
  logic [15:0]       r_out_prob [LANES];

  // S2 combinational: leading-one index and mantissa bits below it
  logic [4:0]          w_e [SLOTS];
  logic [LUT_BITS-1:0] w_f [SLOTS];
  always_comb begin
    for (int s = 0; s < SLOTS; s++) begin
      w_e[s] = lod(r_s1_den[s]);
      // Normalise so the leading one lands on bit 31; f is the field beneath it.
      w_f[s] = LUT_BITS'((r_s1_den[s] << (5'd31 - w_e[s])) >> (31 - LUT_BITS));
    end
  end

  // S4 combinational: optional rounding bias, shift by e+1, saturate to 1.0
  logic [15:0] w_q [LANES];
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      logic [32:0] sum;
      logic [32:0] q;
      sum = {1'b0, r_s3_prod[k]};
`ifdef NORM_ROUND_EN
      sum = sum + (33'd1 << r_s3_e[k / NSEG]);
`endif
      q = sum >> ({1'b0, r_s3_e[k / NSEG]} + 6'd1);
      if (r_s3_zero[k / NSEG])  w_q[k] = 16'h0000;
      else if (q > 33'h8000)    w_q[k] = 16'h8000;
      else                      w_q[k] = q[15:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_vld <= 1'b0; r_s2_vld <= 1'b0; r_s3_vld <= 1'b0; r_out_vld <= 1'b0;
      r_s1_mode <= '0; r_s2_mode <= '0; r_s3_mode <= '0; r_out_mode <= '0;
      r_s2_zero <= '0; r_s3_zero <= '0; r_out_dz <= '0;
      for (int s = 0; s < SLOTS; s++) begin
        r_s1_den[s] <= '0; r_s2_e[s] <= '0; r_s2_r[s] <= '0; r_s3_e[s] <= '0;
      end
      for (int k = 0; k < LANES; k++) begin
        r_s1_lane[k] <= '0; r_s2_lane[k] <= '0; r_s3_prod[k] <= '0; r_out_prob[k] <= '0;
      end
    end else if (i_en) begin
      // S1
      r_s1_vld  <= i_valid;
      r_s1_mode <= i_length_mode;
      for (int s = 0; s < SLOTS; s++) r_s1_den[s] <= w_den[s];
      for (int k = 0; k < LANES; k++) r_s1_lane[k] <= i_in_flat[16*k +: 16];
      // S2
      r_s2_vld  <= r_s1_vld;
      r_s2_mode <= r_s1_mode;
      for (int s = 0; s < SLOTS; s++) begin
        r_s2_e[s]    <= w_e[s];
        r_s2_r[s]    <= w_lut[w_f[s]];
        r_s2_zero[s] <= (r_s1_den[s] == 32'd0);
      end
      for (int k = 0; k < LANES; k++) r_s2_lane[k] <= r_s1_lane[k];
      // S3
      r_s3_vld  <= r_s2_vld;
      r_s3_mode <= r_s2_mode;
      r_s3_zero <= r_s2_zero;
      for (int s = 0; s < SLOTS; s++) r_s3_e[s] <= r_s2_e[s];
      for (int k = 0; k < LANES; k++)
        r_s3_prod[k] <= {16'd0, r_s2_lane[k]} * {16'd0, r_s2_r[k / NSEG]};
      // S4
      r_out_vld  <= r_s3_vld;
      r_out_mode <= r_s3_mode;
      r_out_dz   <= r_s3_zero;
      for (int k = 0; k < LANES; k++) r_out_prob[k] <= w_q[k];
    end
  end

  assign o_valid           = r_out_vld;
  assign o_div_zero        = r_out_dz;
  assign o_length_mode_byp = r_out_mode;
  always_comb begin
    for (int k = 0; k < LANES; k++) o_prob_flat[16*k +: 16] = r_out_prob[k];
  end

endmodule

// File: tb/tb_softmax_normalizer.sv
// Self-checking bench for softmax_normalizer: directed cases plus randomized
// beats (random i_en, valid, mode, sums, occasional reset) checked against a
// 4-entry behavioural pipeline whose entries are computed from plain arithmetic.
module tb_softmax_normalizer;

  typedef struct packed {
    logic              vld;
    logic              chk;
    logic [3:0]        mode;
    logic [3:0]        dz;
    logic [63:0][15:0] p;
  } rec_t;

  logic              clk = 1'b0;
  logic              rst, en, vld;
  logic [3:0]        mode;
  logic [31:0]       gsum, s64;
  logic [31:0]       s32 [2];
  logic [31:0]       s16 [4];
  logic [63:0][15:0] lanes;
  logic              o_valid;
  logic [63:0][15:0] prob_out;
  logic [3:0]        o_div_zero, o_mode;

  int n_chk  = 0;
  int n_fail = 0;
  rec_t pipe [4];

  always #5 clk = ~clk;

  softmax_normalizer dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(vld),
    .i_length_mode(mode), .i_global_sum(gsum), .i_sum64_0(s64),
    .i_sum32_0(s32[0]), .i_sum32_1(s32[1]),
    .i_sum16_0(s16[0]), .i_sum16_1(s16[1]), .i_sum16_2(s16[2]), .i_sum16_3(s16[3]),
    .i_in_flat(lanes), .o_valid(o_valid), .o_prob_flat(prob_out),
    .o_div_zero(o_div_zero), .o_length_mode_byp(o_mode)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: probability = x / S in Q1.15, using a 6-bit-mantissa reciprocal.
  function automatic rec_t model_beat();
    rec_t r;
    longint den, ee, ff, rr, p, q;
    r = '0;
    r.vld = vld; r.chk = vld; r.mode = mode;
    for (int s = 0; s < 4; s++) begin
      case (mode)
        4'd0:    den = longint'(s16[s]);
        4'd1:    den = longint'(s32[s/2]);
        4'd2:    den = longint'(s64);
        default: den = longint'(gsum);
      endcase
      if (den == 0) begin
        r.dz[s] = 1'b1;
      end else begin
        ee = 0;
        while ((den >> (ee + 1)) != 0) ee++;
        ff = ((den << 6) >> ee) - 64;           // mantissa fraction, 0..63
        rr = (64'sd1 << 22) / (64 + ff);
        if (rr > 65535) rr = 65535;
        for (int l = 0; l < 16; l++) begin
          p = longint'(lanes[16*s + l]) * rr;
`ifdef NORM_ROUND_EN
          p = p + (64'sd1 << ee);
`endif
          q = p >> (ee + 1);
          if (q > 32768) q = 32768;
          r.p[16*s + l] = q[15:0];
        end
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) pipe[i] = '0;
      pipe[3].chk = 1'b1;                       // outputs must read zero after reset
    end else if (en) begin
      pipe[3] = pipe[2]; pipe[2] = pipe[1]; pipe[1] = pipe[0];
      pipe[0] = model_beat();
    end
    #1;
    check("o_valid", {31'd0, o_valid}, {31'd0, pipe[3].vld});
    if (pipe[3].chk) begin
      check("mode_byp", {28'd0, o_mode}, {28'd0, pipe[3].mode});
      check("div_zero", {28'd0, o_div_zero}, {28'd0, pipe[3].dz});
      for (int k = 0; k < 64; k++)
        check($sformatf("lane%0d", k), {16'd0, prob_out[k]}, {16'd0, pipe[3].p[k]});
    end
  endtask

  // One valid beat followed by three idle cycles: that beat is then at the output.
  task automatic flush_beat();
    vld = 1'b1; step();
    vld = 1'b0; repeat (3) step();
  endtask

  function automatic logic [31:0] rnd_sum();
    if ($urandom_range(0, 7) == 0) return 32'd0;
    return $urandom >> $urandom_range(0, 31);
  endfunction

  initial begin
    rst = 1'b1; en = 1'b1; vld = 1'b0; mode = '0; gsum = '0; s64 = '0;
    s32[0] = '0; s32[1] = '0;
    for (int s = 0; s < 4; s++) s16[s] = '0;
    lanes = '0;
    repeat (2) step();
    rst = 1'b0;

    // Mode 2, all lanes 0x0100 over 0x4000
    mode = 4'd2; s64 = 32'h4000;
    for (int k = 0; k < 64; k++) lanes[k] = 16'h0100;
    flush_beat();
`ifdef NORM_ROUND_EN
    check("t1_lane0", {16'd0, prob_out[0]}, 32'h0200);
`else
    check("t1_lane0", {16'd0, prob_out[0]}, 32'h01FF);
`endif
    check("t1_dz", {28'd0, o_div_zero}, 32'h0);

    // Mode 0, per-slot sums with slot 3 zero
    mode = 4'd0; s16[0] = 32'h1000; s16[1] = 32'h2000; s16[2] = 32'h4000; s16[3] = 32'h0;
    flush_beat();
`ifndef NORM_ROUND_EN
    check("t2_slot0", {16'd0, prob_out[0]},  32'h07FF);
    check("t2_slot1", {16'd0, prob_out[16]}, 32'h03FF);
    check("t2_slot2", {16'd0, prob_out[32]}, 32'h01FF);
`endif
    check("t2_slot3", {16'd0, prob_out[48]}, 32'h0000);
    check("t2_dz", {28'd0, o_div_zero}, 32'h8);

    // Mode 5, tiny global sum saturates
    mode = 4'd5; gsum = 32'h10; lanes = '0; lanes[0] = 16'h0100;
    flush_beat();
    check("t3_lane0", {16'd0, prob_out[0]}, 32'h8000);
    check("t3_mode", {28'd0, o_mode}, 32'h5);

    // Mode 1, two 32-lane halves
    mode = 4'd1; s32[0] = 32'h8000; s32[1] = 32'h100;
    for (int k = 0; k < 64; k++) lanes[k] = 16'h0100;
    flush_beat();
`ifdef NORM_ROUND_EN
    check("t4_lo", {16'd0, prob_out[0]},  32'h0100);
    check("t4_hi", {16'd0, prob_out[63]}, 32'h8000);
`else
    check("t4_lo", {16'd0, prob_out[0]},  32'h00FF);
    check("t4_hi", {16'd0, prob_out[63]}, 32'h7FFF);
`endif

    // Stall mid-stream: three beats, i_en low for two cycles
    vld = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 64; k++) lanes[k] = 16'($urandom);
      s32[0] = rnd_sum(); s32[1] = rnd_sum();
      step();
      if (b == 1) begin en = 1'b0; repeat (2) step(); en = 1'b1; end
    end
    vld = 1'b0; repeat (5) step();

    // Reset with three beats in flight
    vld = 1'b1; repeat (3) step();
    vld = 1'b0; rst = 1'b1; step();
    rst = 1'b0; repeat (4) step();
    flush_beat();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      rst  = ($urandom_range(0, 99) == 0);
      en   = ($urandom_range(0, 3) != 0);
      vld  = ($urandom_range(0, 3) != 0);
      mode = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) mode = 4'($urandom_range(0, 2));
      gsum = rnd_sum(); s64 = rnd_sum(); s32[0] = rnd_sum(); s32[1] = rnd_sum();
      for (int s = 0; s < 4; s++) s16[s] = rnd_sum();
      for (int k = 0; k < 64; k++) lanes[k] = 16'($urandom);
      step();
    end
    rst = 1'b0; en = 1'b1; vld = 1'b0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
